// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: single-cycle arithmetic/logic ops, iterative shifts of up to
// SHIFT_STEP bits per cycle, registered result and zero/sign/carry/overflow flags.
module alu_multicycle #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_W = SW'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [3:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SW-1:0]    shamt;
  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] shifted;
  logic             set_flags;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign shamt    = B[SW-1:0];
  assign step_amt = (rem_q > STEP_W) ? STEP_W : rem_q;

  // res_q doubles as the shift working register while BUSY
  always_comb begin
    shifted = res_q;
    case (op_q)
      OP_SLL:  shifted = res_q << step_amt;
      OP_SRL:  shifted = res_q >> step_amt;
      OP_SRA:  shifted = $signed(res_q) >>> step_amt;
      default: shifted = res_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    rem_d     = rem_q;
    op_d      = op_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    set_flags = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = DONE;
          op_d      = sel;
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          set_flags = 1'b1;
          case (sel)
            OP_ADD: begin
              res_d   = sum_ext[WIDTH-1:0];
              carry_d = sum_ext[WIDTH];
              ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
              res_d   = diff_ext[WIDTH-1:0];
              carry_d = diff_ext[WIDTH];
              ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  res_d = A ^ B;
            OP_OR:   res_d = A | B;
            OP_AND:  res_d = A & B;
            OP_SLL, OP_SRL, OP_SRA: begin
              res_d = A;
              if (shamt != '0) begin
                rem_d     = shamt;
                state_d   = BUSY;
                set_flags = 1'b0;
              end
            end
            default: res_d = '0;
          endcase
        end
      end
      BUSY: begin
        res_d = shifted;
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d   = DONE;
          set_flags = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (set_flags) begin
      zero_d = (res_d == '0);
      sign_d = res_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      zero_q  <= 1'b1;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign alu_result = res_q;
  assign zero_flag  = zero_q;
  assign sign_flag  = sign_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    sel = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  alu_result;
  logic          zero_flag, sign_flag, carry_flag, ovf_flag;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .carry_flag(carry_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers; shifts done in one go.
  function automatic void model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic v,
                                output int lat);
    longint sx, sy, t;
    logic [63:0] u;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(y[4:0]);
    r = '0; c = 1'b0; v = 1'b0; lat = 1;
    case (s)
      4'd0: begin
        u = {32'b0, x} + {32'b0, y};
        r = u[31:0];
        c = (u > 64'hFFFF_FFFF);
        t = sx + sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd2: begin
        r = x - y;
        c = (x < y);
        t = sx - sy;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd3: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd9: r = (x < y) ? 32'd1 : 32'd0;
      4'd4: r = x ^ y;
      4'd6: r = x | y;
      4'd7: r = x & y;
      4'd1: r = x << sh;
      4'd5: r = x >> sh;
      4'd8: r = $signed(x) >>> sh;
      default: r = '0;
    endcase
    if ((s == 4'd1 || s == 4'd5 || s == 4'd8) && sh > 0) lat = 1 + (sh + STEP - 1) / STEP;
  endfunction

  task automatic run_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    logic [31:0] er;
    logic ec, ev;
    int el, lat;
    model(s, x, y, er, ec, ev, el);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    sel = s; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    // junk requests while busy must be ignored
    sel = 4'($urandom); a = $urandom; b = $urandom;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      sel = 4'($urandom); a = $urandom; b = $urandom;
    end
    check("latency", lat, el);
    check("result", alu_result, er);
    check("zero", zero_flag, (er == 0));
    check("sign", sign_flag, er[31]);
    check("carry", carry_flag, ec);
    check("ovf", ovf_flag, ev);
    $display("op sel=%0d A=%08h B=%08h -> res=%08h z=%0b s=%0b c=%0b v=%0b lat=%0d hold=%0d",
             s, x, y, alu_result, zero_flag, sign_flag, carry_flag, ovf_flag, lat, hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", alu_result, er);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_zero", zero_flag, (er == 0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [3:0]  s;
    #12;
    check("rst_result", alu_result, 32'd0);
    check("rst_zero", zero_flag, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_flags", {sign_flag, carry_flag, ovf_flag}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(4'd2, 32'd3, 32'd5, 0);
    run_op(4'd3, 32'd3, 32'd5, 0);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd8, 32'h8000_0000, 32'd31, 0);
    run_op(4'd5, 32'h8000_0000, 32'd31, 0);
    run_op(4'd1, 32'h1234_5678, 32'h20, 0);
    run_op(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5);
    run_op(4'd2, 32'h8000_0000, 32'd1, 2);

    // reset while a shift is in progress
    @(negedge clk);
    sel = 4'd1; a = 32'h0000_00F1; b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_valid", out_valid, 1'b0);
    check("busy_ready", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", alu_result, 32'd0);
    check("midrst_zero", zero_flag, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_flags", {sign_flag, carry_flag, ovf_flag}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_valid", out_valid, 1'b0);
      check("postrst_ready", in_ready, 1'b1);
    end

    for (int n = 0; n < 150; n++) begin
      s = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x = 32'h7FFF_FFFF;
        1: x = 32'h8000_0000;
        2: y = x;
        3: y = 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op(s, x, y, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
